// File: rtl/transmitter_buffer.sv
//==============================================================================
// Module      : transmitter_buffer
// Description : Transmit-side block buffer between the AES core and the UART
//               transmitter. 128-bit result blocks are queued in a small FIFO
//               and each block is serialised into 16 bytes, MSB byte first.
//               Each byte is handed to the UART with a tx_start/tx_done
//               handshake.
//
// Ports       : clk                    - system clock, rising edge
//               reset                  - synchronous active-high reset
//               block_aes_to_buffer    - 128-bit block to queue
//               write_en               - push block_aes_to_buffer this cycle
//               tx_done                - UART pulse: current byte fully sent
//               byte_buffer_to_UART_tx - registered byte for the UART
//               tx_start               - 1-cycle pulse: UART starts the byte
//               full / empty           - FIFO occupancy flags
//               busy                   - serialiser active (SEND or WAIT)
//               overflow               - sticky: a write was dropped while full
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module transmitter_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] block_aes_to_buffer,
    input  logic         write_en,
    input  logic         tx_done,
    output logic [7:0]   byte_buffer_to_UART_tx,
    output logic         tx_start,
    output logic         full,
    output logic         empty,
    output logic         busy,
    output logic         overflow
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SEND = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;

    localparam logic [ADDR_W:0] c_PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [3:0]      c_LAST_BYTE = 4'd15;

    logic [127:0]    r_mem [DEPTH];
    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_rd_ptr;
    logic [1:0]      r_state;
    logic [127:0]    r_shift;
    logic [3:0]      r_byte_cnt;
    logic            r_launch_pending;
    logic [7:0]      r_byte;
    logic            r_tx_start;
    logic            r_overflow;

    logic            w_empty;
    logic            w_full;
    logic            w_write;
    logic            w_pop;
    logic [127:0]    w_head;

    // Wrap bit distinguishes full from empty when the low address bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                     (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

    // full is taken from the registered pointers, so a write while full is
    // dropped even when the FSM pops in the same cycle.
    assign w_write = write_en && !w_full;
    assign w_pop   = (r_state == c_IDLE) && !w_empty;
    assign w_head  = r_mem[r_rd_ptr[ADDR_W-1:0]];

    // Storage needs no reset: resetting the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= block_aes_to_buffer;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_state          <= c_IDLE;
            r_shift          <= '0;
            r_byte_cnt       <= '0;
            r_launch_pending <= 1'b0;
            r_byte           <= '0;
            r_tx_start       <= 1'b0;
            r_overflow       <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;

            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (write_en && w_full) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                c_IDLE: begin
                    // Outputs are registered on the way into SEND so the
                    // first byte and its start pulse appear in the SEND cycle.
                    if (w_pop) begin
                        r_shift    <= w_head;
                        r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
                        r_byte_cnt <= '0;
                        r_byte     <= w_head[127:120];
                        r_tx_start <= 1'b1;
                        r_state    <= c_SEND;
                    end
                end

                c_SEND: begin
                    r_state <= c_WAIT;
                end

                c_WAIT: begin
                    if (r_launch_pending) begin
                        // The shifted byte is launched one cycle after
                        // tx_done, so the spacing from tx_done to the next
                        // tx_start is the same inside a block and across a
                        // block boundary (where IDLE spends that cycle).
                        r_launch_pending <= 1'b0;
                        r_byte           <= r_shift[127:120];
                        r_tx_start       <= 1'b1;
                        r_state          <= c_SEND;
                    end else if (tx_done) begin
                        r_shift <= r_shift << 8;
                        if (r_byte_cnt == c_LAST_BYTE) begin
                            r_state <= c_IDLE;
                        end else begin
                            r_byte_cnt       <= r_byte_cnt + 4'd1;
                            r_launch_pending <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign byte_buffer_to_UART_tx = r_byte;
    assign tx_start               = r_tx_start;
    assign full                   = w_full;
    assign empty                  = w_empty;
    assign busy                   = (r_state != c_IDLE);
    assign overflow               = r_overflow;

endmodule

`default_nettype wire
